// File: rtl/sonar_scheduler_if.sv
// Bundle between the sonar scheduler and its surroundings: the sonar_driver
// handshake (measure/ready/distance) plus the result bank read by the application.
interface sonar_scheduler_if #(
    parameter int NUM_SONARS = 4
);
    logic                    enable;
    logic [NUM_SONARS-1:0]   sonar_measure;
    logic [NUM_SONARS-1:0]   sonar_ready;
    logic [8*NUM_SONARS-1:0] sonar_distance;
    logic [8*NUM_SONARS-1:0] dist_out;
    logic [NUM_SONARS-1:0]   dist_valid;
    logic [NUM_SONARS-1:0]   dist_timeout;
    logic [3:0]              cur_chan;
    logic                    busy;
    logic                    sweep_done;

    // Environment side: drivers and application logic
    modport master (
        output enable, sonar_ready, sonar_distance,
        input  sonar_measure, dist_out, dist_valid, dist_timeout, cur_chan, busy, sweep_done
    );

    // Scheduler side
    modport slave (
        input  enable, sonar_ready, sonar_distance,
        output sonar_measure, dist_out, dist_valid, dist_timeout, cur_chan, busy, sweep_done
    );
endinterface

// File: rtl/sonar_scheduler.sv
// Round-robin owner of the single sonar measurement slot. Pulses one driver,
// waits for its ready edge or a timeout, holds a quiet gap, then moves on.
module sonar_scheduler #(
    parameter int NUM_SONARS     = 4,
    parameter int FREQ           = 50_000_000,
    parameter int TIMEOUT_CYCLES = FREQ / 25,
    parameter int GAP_CYCLES     = FREQ / 50
) (
    input  logic             clk,
    input  logic             rst,
    sonar_scheduler_if.slave bus
);
    localparam int            CW       = $clog2(NUM_SONARS);
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_SONARS - 1);
    localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   GAP_LAST = 32'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_READY, GAP} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              chan_q;
    logic [31:0]                counter_q;
    logic                       prev_ready_q;
    logic [NUM_SONARS-1:0][7:0] dist_q;
    logic [NUM_SONARS-1:0]      valid_q;
    logic [NUM_SONARS-1:0]      timeout_q;
    logic                       sweep_done_q;

    logic [NUM_SONARS-1:0][7:0] dist_in;
    logic                       sel_ready;
    logic [7:0]                 sel_dist;
    logic                       hit, expire, gap_end, last_ch;

    // Only the channel that owns the slot is looked at; others are ignored.
    assign dist_in   = bus.sonar_distance;
    assign sel_ready = bus.sonar_ready[chan_q];
    assign sel_dist  = dist_in[chan_q];
    assign last_ch   = (chan_q == LAST_CH);

    // A ready level already high at START is stale; only a fresh rising edge
    // counts, and it beats a timeout landing in the same cycle.
    assign hit     = (state_q == WAIT_READY) && sel_ready && !prev_ready_q;
    assign expire  = (state_q == WAIT_READY) && !hit && (counter_q == TO_LAST);
    assign gap_end = (state_q == GAP) && (counter_q == GAP_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: enable is only looked at from IDLE and at the sweep wrap
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (bus.enable) state_d = START;
            START:      state_d = WAIT_READY;
            WAIT_READY: if (hit || expire) state_d = GAP;
            GAP: begin
                if (gap_end) begin
                    if (!last_ch)        state_d = START;
                    else if (bus.enable) state_d = START;
                    else                 state_d = IDLE;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    // FSM outputs: one-hot measure strobe during START, busy outside IDLE
    always_comb begin
        bus.sonar_measure = '0;
        if (state_q == START) bus.sonar_measure[chan_q] = 1'b1;
        bus.busy = (state_q != IDLE);
    end

    // Channel pointer, shared cycle counter, ready history and result bank
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q       <= '0;
            counter_q    <= '0;
            prev_ready_q <= 1'b0;
            dist_q       <= '0;
            valid_q      <= '0;
            timeout_q    <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    chan_q    <= '0;
                    counter_q <= '0;
                end
                START: begin
                    counter_q    <= '0;
                    prev_ready_q <= sel_ready;
                end
                WAIT_READY: begin
                    prev_ready_q <= sel_ready;
                    counter_q    <= counter_q + 32'd1;
                    if (hit) begin
                        dist_q[chan_q]    <= sel_dist;
                        valid_q[chan_q]   <= 1'b1;
                        timeout_q[chan_q] <= 1'b0;
                    end else if (expire) begin
                        dist_q[chan_q]    <= 8'hFF;
                        valid_q[chan_q]   <= 1'b0;
                        timeout_q[chan_q] <= 1'b1;
                    end
                    if (hit || expire) begin
                        counter_q    <= '0;
                        sweep_done_q <= last_ch;
                    end
                end
                GAP: begin
                    counter_q <= counter_q + 32'd1;
                    if (gap_end) begin
                        counter_q <= '0;
                        chan_q    <= last_ch ? '0 : chan_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dist_out     = dist_q;
    assign bus.dist_valid   = valid_q;
    assign bus.dist_timeout = timeout_q;
    assign bus.cur_chan     = 4'(chan_q);
    assign bus.sweep_done   = sweep_done_q;
endmodule

// File: tb/tb_sonar_scheduler.sv
// Bench for sonar_scheduler: emulated sonar drivers, a timestamp-based model
// of the slot schedule checked every cycle, directed scenarios and a random soak.
module tb_sonar_scheduler;
    localparam int N   = 2;
    localparam int TO  = 50;
    localparam int GAP = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sonar_scheduler_if #(.NUM_SONARS(N)) bus ();

    sonar_scheduler #(
        .NUM_SONARS(N), .FREQ(50_000_000), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // bookkeeping
    int vectors = 0;
    int miscompares = 0;
    int cyc = -1;
    bit chk_en = 0;

    // stimulus knobs / emulated drivers
    bit               rst_i, en_i;
    int               d [N];            // response delay after measure, 0 = never answers
    int               rise_at [N];
    int               stale_until [N];  // ready forced high through this cycle
    logic [N-1:0][7:0] dist_val;

    // observations
    int pulse_cyc [N];
    bit pulse_new [N];
    int npulses = 0;
    bit sweep_new;
    int sweep_cyc;
    int nsweeps = 0;

    // model: when the next pulse happens, when the current result was decided
    bit                m_active;
    int                m_chan, m_start, m_res, m_sweep_at;
    bit                m_prev;
    logic [N-1:0][7:0] m_dist;
    logic [N-1:0]      m_val, m_tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_chan = 0; m_start = -1; m_res = -1; m_sweep_at = -1;
        m_prev = 0; m_dist = '0; m_val = '0; m_tmo = '0;
    endtask

    // Advance the model across the clock edge that ends cycle cyc.
    task automatic model_step(input bit r, input bit e, input logic [N-1:0] rdy,
                              input logic [N-1:0][7:0] dv);
        int n;
        n = cyc;
        if (r) begin
            model_reset();
        end else if (!m_active) begin
            if (e) begin m_active = 1; m_chan = 0; m_start = n + 1; m_res = -1; end
        end else if (n == m_start) begin
            m_prev = rdy[m_chan];
        end else if (m_res < 0) begin
            if (rdy[m_chan] && !m_prev) begin
                m_dist[m_chan] = dv[m_chan]; m_val[m_chan] = 1; m_tmo[m_chan] = 0; m_res = n;
            end else if (n - m_start == TO) begin
                m_dist[m_chan] = 8'hFF; m_val[m_chan] = 0; m_tmo[m_chan] = 1; m_res = n;
            end
            m_prev = rdy[m_chan];
            if (m_res == n && m_chan == N - 1) m_sweep_at = n + 1;
        end else if (n - m_res == GAP) begin
            m_res = -1;
            if (m_chan < N - 1) begin
                m_chan++; m_start = n + 1;
            end else begin
                m_chan = 0;
                if (e) m_start = n + 1;
                else   m_active = 0;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] rdy;
        logic [N-1:0] exp_meas;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < N; c++) begin
            if (rst_i) rise_at[c] = -1;
            else if (bus.sonar_measure[c] === 1'b1) begin
                rise_at[c]   = (d[c] > 0) ? cyc + d[c] : -1;
                pulse_cyc[c] = cyc;
                pulse_new[c] = 1;
                npulses++;
            end
            rdy[c] = (cyc <= stale_until[c]) ||
                     (rise_at[c] >= 0 && cyc >= rise_at[c] && cyc < rise_at[c] + 4);
        end
        rst                = rst_i;
        bus.enable         = en_i;
        bus.sonar_ready    = rdy;
        bus.sonar_distance = dist_val;
        #3;
        if (chk_en) begin
            exp_meas = '0;
            if (m_active && cyc == m_start) exp_meas[m_chan] = 1'b1;
            chk("sonar_measure", 32'(bus.sonar_measure), 32'(exp_meas));
            chk("busy",          32'(bus.busy),          32'(m_active));
            chk("cur_chan",      32'(bus.cur_chan),      32'(m_chan));
            chk("dist_out",      32'(bus.dist_out),      32'(m_dist));
            chk("dist_valid",    32'(bus.dist_valid),    32'(m_val));
            chk("dist_timeout",  32'(bus.dist_timeout),  32'(m_tmo));
            chk("sweep_done",    32'(bus.sweep_done),    32'(cyc == m_sweep_at));
        end
        if (bus.sweep_done === 1'b1) begin sweep_new = 1; sweep_cyc = cyc; nsweeps++; end
        model_step(rst_i, en_i, rdy, dist_val);
        if (rst_i) chk_en = 1;
    endtask

    task automatic wait_pulse(input int c, input int budget);
        pulse_new[c] = 0;
        for (int i = 0; i < budget && !pulse_new[c]; i++) tick();
        chk($sformatf("pulse_wait_ch%0d", c), 32'(pulse_new[c]), 32'd1);
    endtask

    task automatic wait_sweep(input int budget);
        sweep_new = 0;
        for (int i = 0; i < budget && !sweep_new; i++) tick();
        chk("sweep_wait", 32'(sweep_new), 32'd1);
    endtask

    initial begin
        int rel, s, np;
        model_reset();
        for (int c = 0; c < N; c++) begin rise_at[c] = -1; stale_until[c] = -1; pulse_cyc[c] = 0; end
        rst = 1; bus.enable = 0; bus.sonar_ready = '0; bus.sonar_distance = '0;
        rst_i = 1; en_i = 0;
        d[0] = 20; d[1] = 30;
        dist_val = {8'h10, 8'h2A};
        repeat (3) tick();

        // reset state
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_meas",  32'(bus.sonar_measure), 32'd0);
        chk("rst_dist",  32'(bus.dist_out), 32'd0);
        chk("rst_valid", 32'(bus.dist_valid), 32'd0);

        // 1: basic sweep
        rst_i = 0; en_i = 1;
        tick();
        rel = cyc;
        wait_pulse(0, 5);
        chk("first_pulse_latency", 32'(pulse_cyc[0] - rel), 32'd1);
        wait_pulse(1, 100);
        chk("ch1_pulse_after_ch0", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd31);
        wait_sweep(100);
        chk("s1_sweep_time", 32'(sweep_cyc - pulse_cyc[1]), 32'd31);
        chk("s1_dist",  32'(bus.dist_out), 32'h102A);
        chk("s1_valid", 32'(bus.dist_valid), 32'b11);
        chk("s1_tmo",   32'(bus.dist_timeout), 32'b00);
        chk("s1_nsweeps", 32'(nsweeps), 32'd1);

        // 2: ch1 never answers
        d[0] = 12; d[1] = 0; dist_val[0] = 8'h33;
        wait_pulse(1, 100);
        wait_sweep(100);
        chk("s2_timeout_time", 32'(sweep_cyc - pulse_cyc[1]), 32'd51);
        chk("s2_dist",  32'(bus.dist_out), 32'hFF33);
        chk("s2_valid", 32'(bus.dist_valid), 32'b01);
        chk("s2_tmo",   32'(bus.dist_timeout), 32'b10);

        // 3: stale ready; ch0 drops then rises again, ch1 stuck high times out
        s = cyc;
        stale_until[0] = s + 25; d[0] = 20; dist_val[0] = 8'h5C;
        stale_until[1] = s + 120; d[1] = 5; dist_val[1] = 8'h99;
        wait_pulse(0, 30);
        chk("s3_gap_to_ch0", 32'(pulse_cyc[0] - s), 32'd10);
        wait_pulse(1, 100);
        chk("s3_ch0_fresh_edge", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd31);
        wait_sweep(100);
        chk("s3_ch1_timeout_time", 32'(sweep_cyc - pulse_cyc[1]), 32'd51);
        chk("s3_dist",  32'(bus.dist_out), 32'hFF5C);
        chk("s3_valid", 32'(bus.dist_valid), 32'b01);
        chk("s3_tmo",   32'(bus.dist_timeout), 32'b10);

        // 4: ch0 edge one cycle late (timeout), ch1 edge on the timeout cycle
        d[0] = 51; dist_val[0] = 8'h77;
        d[1] = 50; dist_val[1] = 8'h44;
        wait_pulse(0, 30);
        wait_pulse(1, 100);
        chk("s4_ch0_timeout_span", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd61);
        wait_sweep(100);
        chk("s4_collision_time", 32'(sweep_cyc - pulse_cyc[1]), 32'd51);
        chk("s4_dist",  32'(bus.dist_out), 32'h44FF);
        chk("s4_valid", 32'(bus.dist_valid), 32'b10);
        chk("s4_tmo",   32'(bus.dist_timeout), 32'b01);

        // 5: enable dropped mid-sweep
        d[0] = 8; d[1] = 9; dist_val = {8'h02, 8'h01};
        wait_pulse(0, 30);
        repeat (3) tick();
        en_i = 0;
        wait_pulse(1, 100);
        wait_sweep(100);
        np = npulses;
        repeat (40) tick();
        chk("s5_no_more_pulses", 32'(npulses - np), 32'd0);
        chk("s5_busy",  32'(bus.busy), 32'd0);
        chk("s5_dist",  32'(bus.dist_out), 32'h0201);
        chk("s5_valid", 32'(bus.dist_valid), 32'b11);

        // 6: reset during GAP
        en_i = 1; d[0] = 5; d[1] = 5;
        wait_pulse(0, 5);
        repeat (8) tick();
        chk("s6_in_gap_valid", 32'(bus.dist_valid[0]), 32'd1);
        rst_i = 1;
        tick();
        rst_i = 0;
        tick();
        chk("s6_busy",  32'(bus.busy), 32'd0);
        chk("s6_dist",  32'(bus.dist_out), 32'd0);
        chk("s6_valid", 32'(bus.dist_valid), 32'd0);
        chk("s6_chan",  32'(bus.cur_chan), 32'd0);
        tick();
        chk("s6_first_pulse_ch0", 32'(bus.sonar_measure), 32'b01);

        // random soak against the model
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < N; c++) begin
                d[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 56));
                dist_val[c] = 8'($urandom);
                if ($urandom_range(0, 149) == 0) stale_until[c] = cyc + int'($urandom_range(1, 80));
            end
            if ($urandom_range(0, 199) == 0) en_i = !en_i;
            rst_i = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
